nfc_data_output: RTL and testbench

NFC_DATA_OUTPUT -- requirements
Module: nfc_data_output

---
 rtl/nfc_data_output.sv | 173 +++++++++++++++++
 tb/tb_nfc_data_output.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nfc_data_output.sv
// Write-path DQ/DQS sequencer for an NFC PHY: buffers the outbound word stream in a
// show-ahead FIFO and frames each burst with a DQS preamble and postamble.
module nfc_data_output #(
    parameter int FifoDepthLog2   = 4,
    parameter int PreambleCycles  = 2,
    parameter int PostambleCycles = 1
) (
    input  logic        iSystemClock,
    input  logic        iModuleReset,
    input  logic        iBufferReset,
    input  logic        iPO_Buff_Valid,
    input  logic [15:0] iPO_Buff_Data,
    input  logic [1:0]  iPO_Buff_Keep,
    input  logic        iPO_Buff_Last,
    output logic        oPO_Buff_Ready,
    input  logic        iPO_Start,
    output logic        oPO_Busy,
    output logic        oPO_Done,
    output logic [15:0] oPO_DQ,
    output logic [1:0]  oPO_DQStrobe,
    output logic        oPO_DQOutEnable,
    output logic        oPO_DQSOutEnable,
    output logic        oPO_Pause
);

    localparam int Depth = 1 << FifoDepthLog2;

    typedef enum logic [1:0] {
        Idle      = 2'd0,
        Preamble  = 2'd1,
        Data      = 2'd2,
        Postamble = 2'd3
    } state_t;

    state_t state;

    logic                     anyReset;
    logic [18:0]              fifoMem [Depth];
    logic [FifoDepthLog2-1:0] wrPtr;
    logic [FifoDepthLog2-1:0] rdPtr;
    logic [FifoDepthLog2:0]   fifoCount;
    logic                     fifoFull;
    logic                     fifoEmpty;
    logic                     pushEn;
    logic                     popEn;
    logic                     dataSlot;
    logic                     lastBeat;
    logic [3:0]               preCnt;
    logic [3:0]               postCnt;
    logic                     headLast;
    logic [1:0]               headKeep;
    logic [15:0]              headData;
    logic [15:0]              beatWord;

    assign anyReset  = iModuleReset | iBufferReset;
    // Count reaches exactly Depth only when full, so its MSB is the full flag.
    assign fifoFull  = fifoCount[FifoDepthLog2];
    assign fifoEmpty = (fifoCount == '0);
    assign pushEn    = iPO_Buff_Valid & ~fifoFull;

    assign oPO_Buff_Ready = ~fifoFull;
    assign oPO_Busy       = (state != Idle);

    assign {headLast, headKeep, headData} = fifoMem[rdPtr];

    // A data slot is a cycle whose registered outputs will carry a beat or a pause.
    always_comb begin
        dataSlot = 1'b0;
        if (state == Preamble && preCnt == 4'd0)
            dataSlot = 1'b1;
        else if (state == Data && !lastBeat)
            dataSlot = 1'b1;
    end

    assign popEn = dataSlot & ~fifoEmpty;

    // Only a burst-final single-byte word pads its upper phase.
    assign beatWord = (headLast && headKeep == 2'b01) ? {8'hFF, headData[7:0]} : headData;

    always_ff @(posedge iSystemClock) begin
        if (pushEn && !anyReset)
            fifoMem[wrPtr] <= {iPO_Buff_Last, iPO_Buff_Keep, iPO_Buff_Data};
    end

    always_ff @(posedge iSystemClock) begin
        if (anyReset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (pushEn)
                wrPtr <= wrPtr + 1'b1;
            if (popEn)
                rdPtr <= rdPtr + 1'b1;
            case ({pushEn, popEn})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    always_ff @(posedge iSystemClock) begin
        if (anyReset) begin
            state            <= Idle;
            preCnt           <= 4'd0;
            postCnt          <= 4'd0;
            lastBeat         <= 1'b0;
            oPO_Done         <= 1'b0;
            oPO_Pause        <= 1'b0;
            oPO_DQ           <= 16'h0000;
            oPO_DQStrobe     <= 2'b00;
            oPO_DQOutEnable  <= 1'b0;
            oPO_DQSOutEnable <= 1'b0;
        end else begin
            oPO_Done  <= 1'b0;
            oPO_Pause <= 1'b0;
            case (state)
                Idle: begin
                    oPO_DQ           <= 16'h0000;
                    oPO_DQStrobe     <= 2'b00;
                    oPO_DQOutEnable  <= 1'b0;
                    oPO_DQSOutEnable <= 1'b0;
                    if (iPO_Start && !fifoEmpty) begin
                        state            <= Preamble;
                        preCnt           <= 4'(PreambleCycles - 1);
                        oPO_DQOutEnable  <= 1'b1;
                        oPO_DQSOutEnable <= 1'b1;
                    end
                end
                Preamble: begin
                    if (preCnt != 4'd0)
                        preCnt <= preCnt - 4'd1;
                    else
                        state <= Data;
                end
                Data: begin
                    if (lastBeat) begin
                        state        <= Postamble;
                        postCnt      <= 4'(PostambleCycles - 1);
                        lastBeat     <= 1'b0;
                        oPO_DQStrobe <= 2'b00;
                    end
                end
                Postamble: begin
                    if (postCnt != 4'd0) begin
                        postCnt <= postCnt - 4'd1;
                    end else begin
                        state            <= Idle;
                        oPO_Done         <= 1'b1;
                        oPO_DQ           <= 16'h0000;
                        oPO_DQOutEnable  <= 1'b0;
                        oPO_DQSOutEnable <= 1'b0;
                    end
                end
                default: state <= Idle;
            endcase

            // Beat or pause for the upcoming DATA cycle; DQ holds across a pause.
            if (dataSlot) begin
                if (!fifoEmpty) begin
                    oPO_DQ       <= beatWord;
                    oPO_DQStrobe <= 2'b01;
                    lastBeat     <= headLast;
                end else begin
                    oPO_DQStrobe <= 2'b00;
                    oPO_Pause    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nfc_data_output.sv
// Scoreboard bench for nfc_data_output: directed burst scenarios plus randomized bursts,
// with a negedge monitor comparing every DQ beat and the framing around it.
module tb_nfc_data_output;

    logic        clk = 1'b0;
    logic        iModuleReset = 1'b1;
    logic        iBufferReset = 1'b0;
    logic        iPO_Buff_Valid = 1'b0;
    logic [15:0] iPO_Buff_Data = 16'h0;
    logic [1:0]  iPO_Buff_Keep = 2'b11;
    logic        iPO_Buff_Last = 1'b0;
    logic        iPO_Start = 1'b0;
    logic        oPO_Buff_Ready;
    logic        oPO_Busy;
    logic        oPO_Done;
    logic [15:0] oPO_DQ;
    logic [1:0]  oPO_DQStrobe;
    logic        oPO_DQOutEnable;
    logic        oPO_DQSOutEnable;
    logic        oPO_Pause;

    nfc_data_output dut (
        .iSystemClock     (clk),
        .iModuleReset     (iModuleReset),
        .iBufferReset     (iBufferReset),
        .iPO_Buff_Valid   (iPO_Buff_Valid),
        .iPO_Buff_Data    (iPO_Buff_Data),
        .iPO_Buff_Keep    (iPO_Buff_Keep),
        .iPO_Buff_Last    (iPO_Buff_Last),
        .oPO_Buff_Ready   (oPO_Buff_Ready),
        .iPO_Start        (iPO_Start),
        .oPO_Busy         (oPO_Busy),
        .oPO_Done         (oPO_Done),
        .oPO_DQ           (oPO_DQ),
        .oPO_DQStrobe     (oPO_DQStrobe),
        .oPO_DQOutEnable  (oPO_DQOutEnable),
        .oPO_DQSOutEnable (oPO_DQSOutEnable),
        .oPO_Pause        (oPO_Pause)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] expQ[$];
    int          modelCount = 0;
    bit          armed = 0;
    bit          pendRst = 0;
    bit          pendPush = 0;
    logic [15:0] pendBeat = 16'h0;
    logic [15:0] prevDQ = 16'h0;
    logic [15:0] expWord;
    bit          seenBeat = 0;
    int          preLen = 0, postLen = 0, busyLen = 0, burstPauses = 0;
    int          lastBusyLen = 0, lastPauses = 0;
    int          doneCount = 0;
    int          pushed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor/scoreboard: applies the previous edge's push/reset to the model, then checks.
    always @(negedge clk) begin
        if (pendRst) begin
            expQ.delete();
            modelCount = 0;
            seenBeat = 0; preLen = 0; postLen = 0; busyLen = 0; burstPauses = 0;
            armed = 1;
        end else if (pendPush) begin
            expQ.push_back(pendBeat);
            modelCount++;
        end
        if (armed) begin
            if (oPO_DQStrobe == 2'b01) begin
                if (expQ.size() == 0) begin
                    check("beat_unexpected", 32'(oPO_DQ), 32'hFFFF_FFFF);
                end else begin
                    expWord = expQ.pop_front();
                    check("beat_data", 32'(oPO_DQ), 32'(expWord));
                end
                modelCount--;
                seenBeat = 1;
                postLen = 0;
            end
            if (!oPO_Busy) begin
                check("idle_outputs", 32'({oPO_DQOutEnable, oPO_DQSOutEnable, oPO_DQStrobe, oPO_DQ, oPO_Pause}), 32'h0);
            end else begin
                busyLen++;
                check("enables", 32'({oPO_DQOutEnable, oPO_DQSOutEnable}), 32'h3);
                if (oPO_DQStrobe != 2'b01) begin
                    if (!seenBeat) begin
                        preLen++;
                        check("preamble", 32'({oPO_DQStrobe, oPO_DQ, oPO_Pause}), 32'h0);
                    end else begin
                        postLen++;
                        check("dq_hold", 32'({oPO_DQStrobe, oPO_DQ}), 32'({2'b00, prevDQ}));
                        if (oPO_Pause) burstPauses++;
                    end
                end
            end
            check("ready", 32'(oPO_Buff_Ready), 32'(modelCount < 16));
            if (oPO_Done) begin
                doneCount++;
                check("done_preamble_len", 32'(preLen), 32'd2);
                check("done_postamble_len", 32'(postLen), 32'd1);
                check("done_drained", 32'(expQ.size()), 32'd0);
                lastBusyLen = busyLen;
                lastPauses = burstPauses;
                seenBeat = 0; preLen = 0; postLen = 0; busyLen = 0; burstPauses = 0;
            end
        end
        prevDQ = oPO_DQ;
        pendRst = iModuleReset | iBufferReset;
        pendPush = iPO_Buff_Valid && oPO_Buff_Ready && !pendRst;
        pendBeat = (iPO_Buff_Last && iPO_Buff_Keep == 2'b01) ? {8'hFF, iPO_Buff_Data[7:0]} : iPO_Buff_Data;
    end

    // All tasks start and end at posedge+1.
    task automatic push_word(input logic [15:0] d, input logic [1:0] k, input logic l);
        int n = 0;
        iPO_Buff_Valid = 1'b1; iPO_Buff_Data = d; iPO_Buff_Keep = k; iPO_Buff_Last = l;
        do begin
            @(negedge clk);
            n++;
        end while (!oPO_Buff_Ready && n < 300);
        if (!oPO_Buff_Ready) check("push_timeout", 32'(oPO_Buff_Ready), 32'd1);
        @(posedge clk); #1;
        iPO_Buff_Valid = 1'b0;
        pushed++;
    endtask

    task automatic pulse_start();
        iPO_Start = 1'b1;
        @(posedge clk); #1;
        iPO_Start = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (doneCount < target && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("done_seen", 32'(doneCount >= target), 32'd1);
    endtask

    initial begin
        int doneBefore;
        int nWords, startAfter;
        bit found;

        wait_cycles(3);
        iModuleReset = 1'b0;
        wait_cycles(1);
        check("reset_state", 32'({oPO_Busy, oPO_Done, oPO_Pause, oPO_Buff_Ready}), 32'h1);

        // Four-word burst: 2 preamble, 4 beats, 1 postamble.
        push_word(16'h0201, 2'b11, 1'b0);
        push_word(16'h0403, 2'b11, 1'b0);
        push_word(16'h0605, 2'b11, 1'b0);
        push_word(16'h0807, 2'b11, 1'b1);
        pulse_start();
        wait_done(1);
        check("busy_len_basic", 32'(lastBusyLen), 32'd7);
        wait_cycles(2);

        // Underrun mid-burst must pause with DQ held.
        push_word(16'hA1A2, 2'b11, 1'b0);
        pulse_start();
        wait_cycles(3);
        push_word(16'hB1B2, 2'b11, 1'b0);
        push_word(16'hC1C2, 2'b11, 1'b1);
        wait_done(2);
        check("pause_seen", 32'(lastPauses > 0), 32'd1);
        wait_cycles(2);

        // Single-byte words: padded only when last.
        push_word(16'h1234, 2'b01, 1'b0);
        push_word(16'h00AB, 2'b01, 1'b1);
        pulse_start();
        wait_done(3);
        wait_cycles(2);

        // Fill to full, then a rejected 17th word.
        for (int i = 0; i < 16; i++)
            push_word(16'(16'h5000 + i), 2'b11, 1'(i == 15));
        check("full_not_ready", 32'(oPO_Buff_Ready), 32'd0);
        iPO_Buff_Valid = 1'b1; iPO_Buff_Data = 16'hDEAD; iPO_Buff_Keep = 2'b11; iPO_Buff_Last = 1'b1;
        wait_cycles(3);
        iPO_Buff_Valid = 1'b0;
        pulse_start();
        wait_done(4);
        check("empty_after_full", 32'(oPO_Buff_Ready), 32'd1);
        wait_cycles(2);

        // Abort on the second beat.
        push_word(16'h0201, 2'b11, 1'b0);
        push_word(16'h0403, 2'b11, 1'b0);
        push_word(16'h0605, 2'b11, 1'b0);
        push_word(16'h0807, 2'b11, 1'b1);
        doneBefore = doneCount;
        pulse_start();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (oPO_DQStrobe == 2'b01 && oPO_DQ == 16'h0403) found = 1;
            else wait_cycles(1);
        end
        check("abort_beat_found", 32'(found), 32'd1);
        iBufferReset = 1'b1;
        wait_cycles(1);
        iBufferReset = 1'b0;
        check("abort_idle", 32'({oPO_Busy, oPO_DQOutEnable, oPO_DQSOutEnable, oPO_Buff_Ready}), 32'h1);
        wait_cycles(10);
        check("abort_no_done", 32'(doneCount), 32'(doneBefore));

        // Start with an empty FIFO is ignored.
        pulse_start();
        wait_cycles(1);
        check("start_empty_busy", 32'(oPO_Busy), 32'd0);
        wait_cycles(2);
        check("start_empty_busy_late", 32'(oPO_Busy), 32'd0);

        // Module reset wins over a simultaneous push and start.
        push_word(16'h7777, 2'b11, 1'b0);
        push_word(16'h8888, 2'b11, 1'b1);
        iModuleReset = 1'b1; iPO_Start = 1'b1;
        iPO_Buff_Valid = 1'b1; iPO_Buff_Data = 16'h9999; iPO_Buff_Last = 1'b1;
        wait_cycles(1);
        iModuleReset = 1'b0; iPO_Start = 1'b0; iPO_Buff_Valid = 1'b0;
        check("reset_priority", 32'({oPO_Busy, oPO_Buff_Ready}), 32'h1);
        pulse_start();
        wait_cycles(2);
        check("reset_flushed", 32'(oPO_Busy), 32'd0);

        // Randomized bursts with gaps, late start and stray starts while busy.
        for (int b = 0; b < 25; b++) begin
            nWords = $urandom_range(1, 8);
            startAfter = pushed + $urandom_range(1, nWords);
            fork
                begin
                    for (int w = 0; w < nWords; w++) begin
                        push_word(16'($urandom), ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b01, 1'(w == nWords - 1));
                        if ($urandom_range(0, 2) == 0) wait_cycles($urandom_range(1, 3));
                    end
                end
                begin
                    wait (pushed >= startAfter);
                    pulse_start();
                    wait_cycles($urandom_range(1, 4));
                    if (oPO_Busy) pulse_start();
                end
            join
            wait_done(4 + b + 1);
            wait_cycles($urandom_range(1, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
